// File: rtl/ecc_pkg.sv
// Shared widths and encodings for the ECC scrub controller slice.
package ecc_pkg;
  localparam int CODE_W = 32;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, RD, CHK, WB} state_e;
  typedef enum logic {HOST, SCRUB} owner_e;
endpackage

// File: rtl/ecc_scrub_timer.sv
// Scrub interval timer, single-entry scrub pending flag and wrapping scrub address.
module ecc_scrub_timer #(
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scrub_en_i,
  input  logic              clr_pend_i,
  input  logic              adv_addr_i,
  output logic              scrub_pend_o,
  output logic [ADDR_W-1:0] scrub_addr_o
);
  localparam int TW = $clog2(SCRUB_INTERVAL);
  localparam logic [TW-1:0]     T_LAST = TW'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);

  logic [TW-1:0]     cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tick;

  always_comb begin
    tick   = scrub_en_i && (cnt_q == T_LAST);
    cnt_d  = '0;
    pend_d = pend_q;
    addr_d = addr_q;
    if (scrub_en_i && !tick) cnt_d = cnt_q + 1'b1;
    // clear beats tick: a tick while pending is a dropped tick anyway
    if (!scrub_en_i || clr_pend_i) pend_d = 1'b0;
    else if (tick)                 pend_d = 1'b1;
    if (adv_addr_i) addr_d = (addr_q == A_LAST) ? '0 : addr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      addr_q <= addr_d;
    end
  end

  assign scrub_pend_o = pend_q;
  assign scrub_addr_o = addr_q;
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Host/scrub arbiter and access sequencer for a 2D-ECC codeword memory.
// Define ECC_SCRUB_WB_EN to write corrected codewords back after a CE.
module ecc_scrub_ctrl
  import ecc_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [ADDR_W-1:0] host_req_addr,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] host_rsp_data,
  output logic              host_rsp_ue,
  input  logic              scrub_en,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CODE_W-1:0] mem_wdata,
  input  logic [CODE_W-1:0] mem_rdata,
  output logic [CODE_W-1:0] dec_code,
  input  logic [DATA_W-1:0] dec_data,
  input  logic              dec_ce,
  input  logic              dec_ue,
  output logic [DATA_W-1:0] enc_data,
  input  logic [CODE_W-1:0] enc_code,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  output logic              scrub_busy
);
  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_host_q, last_host_d;
  logic              live_q;
  logic              rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_ue_q, rsp_ue_d;
  logic [CNT_W-1:0]  ce_q, ce_d, ue_q, ue_d;
  logic              scrub_pend, clr_pend, adv_addr, host_grant;
  logic [ADDR_W-1:0] scrub_addr;
  logic              rd_c, wr_c;
`ifdef ECC_SCRUB_WB_EN
  logic [DATA_W-1:0] enc_q, enc_d;
`endif

  ecc_scrub_timer #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SCRUB_INTERVAL(SCRUB_INTERVAL)
  ) u_timer (
    .clk(clk), .rst_n(rst_n), .scrub_en_i(scrub_en),
    .clr_pend_i(clr_pend), .adv_addr_i(adv_addr),
    .scrub_pend_o(scrub_pend), .scrub_addr_o(scrub_addr)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    last_host_d    = last_host_q;
    rsp_vld_d      = 1'b0;
    rsp_data_d     = rsp_data_q;
    rsp_ue_d       = rsp_ue_q;
    ce_d           = ce_q;
    ue_d           = ue_q;
    clr_pend       = 1'b0;
    adv_addr       = 1'b0;
    host_grant     = 1'b0;
    host_req_ready = 1'b0;
    rd_c           = 1'b0;
    wr_c           = 1'b0;
`ifdef ECC_SCRUB_WB_EN
    enc_d          = enc_q;
`endif
    case (state_q)
      IDLE: begin
        // a pending scrub waits at most one host access
        host_grant     = host_req_valid && !(scrub_pend && last_host_q);
        host_req_ready = live_q && !(scrub_pend && (last_host_q || !host_req_valid));
        if (host_grant) begin
          owner_d     = HOST;
          addr_d      = host_req_addr;
          last_host_d = 1'b1;
          state_d     = RD;
        end else if (scrub_pend) begin
          owner_d     = SCRUB;
          addr_d      = scrub_addr;
          last_host_d = 1'b0;
          clr_pend    = 1'b1;
          state_d     = RD;
        end
      end
      RD: begin
        rd_c    = 1'b1;
        state_d = CHK;
      end
      CHK: begin
        if (dec_ue) begin
          if (ue_q != '1) ue_d = ue_q + 1'b1;
        end else if (dec_ce) begin
          if (ce_q != '1) ce_d = ce_q + 1'b1;
        end
        if (owner_q == HOST) begin
          rsp_vld_d  = 1'b1;
          rsp_data_d = dec_data;
          rsp_ue_d   = dec_ue;
        end else begin
          adv_addr = 1'b1;
        end
        state_d = IDLE;
`ifdef ECC_SCRUB_WB_EN
        enc_d = dec_data;
        if (dec_ce && !dec_ue) state_d = WB;
`endif
      end
      WB: begin
`ifdef ECC_SCRUB_WB_EN
        wr_c = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= HOST;
      addr_q      <= '0;
      last_host_q <= 1'b0;
      live_q      <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ue_q    <= 1'b0;
      ce_q        <= '0;
      ue_q        <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      last_host_q <= last_host_d;
      live_q      <= 1'b1;
      rsp_vld_q   <= rsp_vld_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ue_q    <= rsp_ue_d;
      ce_q        <= ce_d;
      ue_q        <= ue_d;
    end
  end

`ifdef ECC_SCRUB_WB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) enc_q <= '0;
    else        enc_q <= enc_d;
  end
  assign enc_data = enc_q;
`else
  assign enc_data = '0;
`endif

  // memory-facing buses are held at zero whenever they carry no meaning
  assign mem_rd_en      = rd_c;
  assign mem_wr_en      = wr_c;
  assign mem_addr       = (rd_c || wr_c) ? addr_q : '0;
  assign mem_wdata      = wr_c ? enc_code : '0;
  assign dec_code       = (state_q == CHK) ? mem_rdata : '0;
  assign host_rsp_valid = rsp_vld_q;
  assign host_rsp_data  = rsp_data_q;
  assign host_rsp_ue    = rsp_ue_q;
  assign ce_count       = ce_q;
  assign ue_count       = ue_q;
  assign scrub_busy     = (state_q != IDLE) && (owner_q == SCRUB);
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a behavioural memory and a toy duplicate-half codec.
module tb_ecc_scrub_ctrl;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 8;
  localparam int SI     = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              host_req_valid = 1'b0;
  logic              host_req_ready;
  logic [ADDR_W-1:0] host_req_addr = '0;
  logic              host_rsp_valid;
  logic [15:0]       host_rsp_data;
  logic              host_rsp_ue;
  logic              scrub_en = 1'b0;
  logic              mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata, dec_code, enc_code;
  logic [15:0]       dec_data, enc_data, diff;
  logic              dec_ce, dec_ue;
  logic [CNT_W-1:0]  ce_count, ue_count;
  logic              scrub_busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ecc_scrub_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_req_addr(host_req_addr),
    .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data), .host_rsp_ue(host_rsp_ue),
    .scrub_en(scrub_en), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dec_code(dec_code), .dec_data(dec_data),
    .dec_ce(dec_ce), .dec_ue(dec_ue), .enc_data(enc_data), .enc_code(enc_code),
    .ce_count(ce_count), .ue_count(ue_count), .scrub_busy(scrub_busy)
  );

  // codeword = {data, data}; corruption is only injected into the low half
  assign diff     = dec_code[31:16] ^ dec_code[15:0];
  assign dec_ce   = ($countones(diff) == 1);
  assign dec_ue   = ($countones(diff) >= 2);
  assign dec_data = dec_ce ? dec_code[31:16] : dec_code[15:0];
  assign enc_code = {enc_data, enc_data};

  logic [31:0]       mem [0:255];
  logic              init_q = 1'b0;
  logic              poke_en = 1'b0;
  logic [7:0]        poke_addr = '0;
  logic [31:0]       poke_data = '0;
  int                wr_cnt = 0;
  logic [7:0]        wr_addr = '0;
  logic [31:0]       wr_data = '0;

  always @(posedge clk) begin
    if (!init_q) begin
      for (int a = 0; a < 256; a++) mem[a] <= {16'h1000 + 16'(a), 16'h1000 + 16'(a)};
      init_q <= 1'b1;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      wr_addr       <= mem_addr;
      wr_data       <= mem_wdata;
    end
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk); poke_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [117:0] v;
    v = {host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_ue, mem_rd_en, mem_wr_en,
         mem_addr, mem_wdata, dec_code, enc_data, ce_count, ue_count, scrub_busy};
    nvec++;
    if (v !== '0) begin
      nerr++; $display("FAIL %s outputs: got %h expected 0", tag, v);
    end
  endtask

  // accept at cycle T; sample T+1..T+4 on falling edges
  task automatic host_read(input logic [7:0] a, input logic [15:0] ed, input logic eue, input string tag);
    @(negedge clk); host_req_valid = 1'b1; host_req_addr = a; #1;
    nvec++;
    if (host_req_ready !== 1'b1) begin nerr++; $display("FAIL %s ready: got %b expected 1", tag, host_req_ready); end
    @(negedge clk); host_req_valid = 1'b0;
    nvec++;
    if (mem_rd_en !== 1'b1 || mem_addr !== a) begin
      nerr++; $display("FAIL %s rd: got en=%b addr=%h expected en=1 addr=%h", tag, mem_rd_en, mem_addr, a);
    end
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      nvec++;
      if (host_rsp_valid !== (k == 3)) begin
        nerr++; $display("FAIL %s rsp_valid T+%0d: got %b expected %b", tag, k, host_rsp_valid, (k == 3));
      end
      if (k >= 3) begin
        nvec++;
        if ({host_rsp_data, host_rsp_ue} !== {ed, eue}) begin
          nerr++; $display("FAIL %s rsp T+%0d: got %h/%b expected %h/%b", tag, k, host_rsp_data, host_rsp_ue, ed, eue);
        end
      end
    end
  endtask

  task automatic test_reset();
    #2 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    nvec++;
    if (host_req_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b expected 1", host_req_ready); end
  endtask

  task automatic test_clean_read();
    host_read(8'd5, 16'hA5A5, 1'b0, "clean");
    nvec++;
    if ({ce_count, ue_count, wr_cnt} !== {4'd0, 4'd0, 32'd0}) begin
      nerr++; $display("FAIL clean_cnt: got ce=%0d ue=%0d wr=%0d expected 0 0 0", ce_count, ue_count, wr_cnt);
    end
  endtask

  task automatic test_ce_read();
    int w0, ew;
    w0 = wr_cnt;
`ifdef ECC_SCRUB_WB_EN
    ew = 1;
`else
    ew = 0;
`endif
    host_read(8'd7, 16'h1234, 1'b0, "ce");
    nvec++;
    if (ce_count !== 4'd1) begin nerr++; $display("FAIL ce_cnt: got %0d expected 1", ce_count); end
    nvec++;
    if (wr_cnt - w0 !== ew) begin nerr++; $display("FAIL ce_wb_cnt: got %0d expected %0d", wr_cnt - w0, ew); end
    if (ew == 1) begin
      nvec++;
      if (wr_addr !== 8'd7 || wr_data !== 32'h1234_1234) begin
        nerr++; $display("FAIL ce_wb: got addr=%h data=%h expected 07 12341234", wr_addr, wr_data);
      end
    end
  endtask

  task automatic test_ue_saturate();
    int w0;
    w0 = wr_cnt;
    host_read(8'd9, 16'hBEEC, 1'b1, "ue");
    nvec++;
    if (ue_count !== 4'd1) begin nerr++; $display("FAIL ue_cnt: got %0d expected 1", ue_count); end
    for (int i = 0; i < 14; i++) host_read(8'd9, 16'hBEEC, 1'b1, "ue_rep");
    nvec++;
    if (ue_count !== 4'd15) begin nerr++; $display("FAIL ue_cnt15: got %0d expected 15", ue_count); end
    for (int i = 0; i < 2; i++) host_read(8'd9, 16'hBEEC, 1'b1, "ue_sat");
    nvec++;
    if ({ue_count, ce_count} !== {4'd15, 4'd1}) begin
      nerr++; $display("FAIL ue_sat: got ue=%0d ce=%0d expected 15 1", ue_count, ce_count);
    end
    nvec++;
    if (wr_cnt !== w0) begin nerr++; $display("FAIL ue_nowb: got %0d writes expected 0", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    logic seen;
    w0 = wr_cnt;
    seen = 1'b0;
    @(negedge clk); host_req_valid = 1'b1; host_req_addr = 8'd7;
    @(negedge clk); host_req_valid = 1'b0;
    rst_n = 1'b0; #1;
    check_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (host_rsp_valid || mem_rd_en || mem_wr_en) seen = 1'b1;
    end
    nvec++;
    if (seen !== 1'b0 || wr_cnt !== w0) begin
      nerr++; $display("FAIL rst_mid_quiet: got activity=%b writes=%0d expected 0 0", seen, wr_cnt - w0);
    end
    nvec++;
    if ({ce_count, ue_count} !== 8'h00) begin
      nerr++; $display("FAIL rst_mid_cnt: got ce=%0d ue=%0d expected 0 0", ce_count, ue_count);
    end
  endtask

  task automatic test_scrub_timing();
    int n;
    n = 0;
    @(negedge clk); scrub_en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin n = i; break; end
    end
    scrub_en = 1'b0;
    nvec++;
    if (n !== 17 || scrub_busy !== 1'b1 || mem_addr !== 8'd0) begin
      nerr++; $display("FAIL scrub_first: got cyc=%0d busy=%b addr=%h expected 17 1 00", n, scrub_busy, mem_addr);
    end
    @(negedge clk);
    nvec++;
    if (scrub_busy !== 1'b1) begin nerr++; $display("FAIL scrub_inflight: got busy=%b expected 1", scrub_busy); end
  endtask

  task automatic test_scrub_disable();
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_rd_en) n++;
    end
    nvec++;
    if (n !== 0) begin nerr++; $display("FAIL scrub_off: got %0d reads expected 0", n); end
  endtask

  task automatic test_back_to_back();
    int nscrub, w0, ew, prev;
    logic [7:0] exp_a;
    nscrub = 0; prev = 2; exp_a = 8'd1;
`ifdef ECC_SCRUB_WB_EN
    ew = 1;
`else
    ew = 0;
`endif
    poke(8'd7, {16'h1234, 16'h1224});
    w0 = wr_cnt;
    @(negedge clk); host_req_valid = 1'b1; host_req_addr = 8'd5; scrub_en = 1'b1;
    for (int i = 0; i < 400 && nscrub < 10; i++) begin
      @(negedge clk);
      if (host_rsp_valid) begin
        nvec++;
        if ({host_rsp_data, host_rsp_ue} !== {16'hA5A5, 1'b0}) begin
          nerr++; $display("FAIL b2b_rsp: got %h/%b expected a5a5/0", host_rsp_data, host_rsp_ue);
        end
      end
      if (mem_rd_en) begin
        if (scrub_busy) begin
          nvec++;
          if (mem_addr !== exp_a || prev !== 0) begin
            nerr++; $display("FAIL b2b_scrub: got addr=%h prev=%0d expected addr=%h prev=0", mem_addr, prev, exp_a);
          end
          exp_a = (exp_a == 8'(DEPTH - 1)) ? 8'd0 : exp_a + 8'd1;
          nscrub++;
          prev = 1;
        end else begin
          prev = 0;
        end
      end
    end
    host_req_valid = 1'b0; scrub_en = 1'b0;
    repeat (6) @(negedge clk);
    nvec++;
    if (nscrub !== 10) begin nerr++; $display("FAIL b2b_budget: got %0d scrubs expected 10", nscrub); end
    nvec++;
    if (ce_count !== 4'd1 || wr_cnt - w0 !== ew) begin
      nerr++; $display("FAIL b2b_ce: got ce=%0d wr=%0d expected 1 %0d", ce_count, wr_cnt - w0, ew);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    poke(8'd5, {16'hA5A5, 16'hA5A5});
    poke(8'd7, {16'h1234, 16'h1224});
    poke(8'd9, {16'hBEEF, 16'hBEEC});
    test_clean_read();
    test_ce_read();
    test_ue_saturate();
    test_reset_mid();
    test_scrub_timing();
    test_scrub_disable();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
